// File: rtl/ntt_load_scheduler.sv
// Sequencing controller between the UART word stream and the NTT core: buffers twiddles,
// fans them out to the per-stage twiddle RAMs, then buffers and streams coefficients per transform.
module ntt_load_scheduler #(
  parameter int W          = 32,
  parameter int RADIX      = 16,
  parameter int ADDR_WIDTH = $clog2(RADIX/2),
  parameter int NUM_STAGES = $clog2(RADIX)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid_i,
  input  logic [W-1:0]          in_data_i,
  output logic                  in_ready_o,
  input  logic                  tw_reload_i,
  output logic [NUM_STAGES-1:0] tw_we_o,
  output logic [ADDR_WIDTH-1:0] tw_addr_o,
  output logic [W-1:0]          tw_data_o,
  output logic                  ntt_start_o,
  output logic                  ntt_valid_o,
  output logic [W-1:0]          ntt_data_o,
  input  logic                  ntt_done_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  overflow_o,
  output logic [2:0]            dbg_state
);

  localparam int HALF = RADIX / 2;
  localparam int CW   = $clog2(RADIX + 1);
  localparam int IW   = $clog2(RADIX);
  localparam int SW   = $clog2(NUM_STAGES + 1);

  typedef enum logic [2:0] {
    ST_TW_RX   = 3'd0,
    ST_TW_WR   = 3'd1,
    ST_COEF_RX = 3'd2,
    ST_STREAM  = 3'd3,
    ST_WAIT    = 3'd4
  } state_t;

  state_t                state;
  logic [CW-1:0]         tcnt;
  logic [CW-1:0]         ccnt;
  logic [IW-1:0]         kcnt;
  logic [SW-1:0]         stage;
  logic [ADDR_WIDTH-1:0] j;

  logic [W-1:0] twbuf [HALF];
  logic [W-1:0] cbuf  [RADIX];

  logic                  accept;
  logic                  reload_hit;
  logic                  tw_store;
  logic                  c_store;
  logic [ADDR_WIDTH-1:0] j_last;
  logic [ADDR_WIDTH-1:0] j_next;
  logic [SW-1:0]         s_next;
  logic [ADDR_WIDTH-1:0] rd_idx;
  logic                  wr_last;
  logic [IW-1:0]         k_next;

  // Acceptance follows the registered ready flag, so valid/ready are judged on the same cycle:
  // a word is taken when in_valid_i=1 and in_ready_o=1, otherwise it is dropped and flagged.
  always_comb begin
    accept     = in_valid_i && in_ready_o;
    reload_hit = (state == ST_COEF_RX) && tw_reload_i && (ccnt == '0);
    tw_store   = (state == ST_TW_RX) && accept;
    c_store    = (state == ST_COEF_RX) && accept && !reload_hit;
    j_last     = ADDR_WIDTH'((HALF >> stage) - 1);
    wr_last    = (stage == SW'(NUM_STAGES - 1)) && (j == j_last);
    if (j == j_last) begin
      s_next = stage + 1'b1;
      j_next = '0;
    end else begin
      s_next = stage;
      j_next = j + 1'b1;
    end
    rd_idx = j_next << s_next;
    k_next = kcnt + 1'b1;
  end

  // Buffers carry no reset: their contents are only trusted after a fresh load.
  always_ff @(posedge clk) begin
    if (tw_store) twbuf[tcnt[ADDR_WIDTH-1:0]] <= in_data_i;
    if (c_store)  cbuf[ccnt[IW-1:0]]          <= in_data_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_TW_RX;
      tcnt        <= '0;
      ccnt        <= '0;
      kcnt        <= '0;
      stage       <= '0;
      j           <= '0;
      in_ready_o  <= 1'b0;
      tw_we_o     <= '0;
      tw_addr_o   <= '0;
      tw_data_o   <= '0;
      ntt_start_o <= 1'b0;
      ntt_valid_o <= 1'b0;
      ntt_data_o  <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      overflow_o  <= 1'b0;
    end else begin
      ntt_start_o <= 1'b0;
      done_o      <= 1'b0;
      if (in_valid_i && !in_ready_o) overflow_o <= 1'b1;

      case (state)
        ST_TW_RX: begin
          in_ready_o <= 1'b1;
          if (accept) begin
            tcnt <= tcnt + 1'b1;
            if (tcnt == CW'(HALF - 1)) begin
              // First write (stage 0, address 0) goes out together with the state change.
              state      <= ST_TW_WR;
              in_ready_o <= 1'b0;
              busy_o     <= 1'b1;
              stage      <= '0;
              j          <= '0;
              tw_we_o    <= NUM_STAGES'(1);
              tw_addr_o  <= '0;
              tw_data_o  <= twbuf[0];
            end
          end
        end

        ST_TW_WR: begin
          if (wr_last) begin
            state      <= ST_COEF_RX;
            tw_we_o    <= '0;
            busy_o     <= 1'b0;
            in_ready_o <= 1'b1;
            ccnt       <= '0;
          end else begin
            stage     <= s_next;
            j         <= j_next;
            tw_we_o   <= NUM_STAGES'(1) << s_next;
            tw_addr_o <= j_next;
            tw_data_o <= twbuf[rd_idx];
          end
        end

        ST_COEF_RX: begin
          // A reload takes priority; a word arriving on the same cycle is discarded.
          if (reload_hit) begin
            state <= ST_TW_RX;
            tcnt  <= '0;
          end else if (accept) begin
            ccnt <= ccnt + 1'b1;
            if (ccnt == CW'(RADIX - 1)) begin
              state       <= ST_STREAM;
              in_ready_o  <= 1'b0;
              busy_o      <= 1'b1;
              ntt_start_o <= 1'b1;
              ntt_valid_o <= 1'b1;
              ntt_data_o  <= cbuf[0];
              kcnt        <= '0;
            end
          end
        end

        ST_STREAM: begin
          if (kcnt == IW'(RADIX - 1)) begin
            state       <= ST_WAIT;
            ntt_valid_o <= 1'b0;
          end else begin
            kcnt       <= k_next;
            ntt_data_o <= cbuf[k_next];
          end
        end

        ST_WAIT: begin
          if (ntt_done_i) begin
            state      <= ST_COEF_RX;
            done_o     <= 1'b1;
            busy_o     <= 1'b0;
            in_ready_o <= 1'b1;
            ccnt       <= '0;
          end
        end

        default: begin
          state      <= ST_TW_RX;
          tw_we_o    <= '0;
          busy_o     <= 1'b0;
          in_ready_o <= 1'b0;
        end
      endcase
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_ntt_load_scheduler.sv
// Directed bench for ntt_load_scheduler: twiddle fan-out, coefficient streaming,
// overflow, reload handling and asynchronous abort.
module tb_ntt_load_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid_i = 1'b0;
  logic [31:0] in_data_i = '0;
  logic        in_ready_o;
  logic        tw_reload_i = 1'b0;
  logic [3:0]  tw_we_o;
  logic [2:0]  tw_addr_o;
  logic [31:0] tw_data_o;
  logic        ntt_start_o;
  logic        ntt_valid_o;
  logic [31:0] ntt_data_o;
  logic        ntt_done_i = 1'b0;
  logic        busy_o;
  logic        done_o;
  logic        overflow_o;
  logic [2:0]  dbg_state;

  int total = 0;
  int bad = 0;
  int tw_we_cnt = 0;
  logic [63:0] exp_q[$];

  // Write order for RADIX=16: stage, address, twiddle offset of each of the 15 writes.
  int tw_st [15] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 3};
  int tw_ad [15] = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1, 2, 3, 0, 1, 0};
  int tw_off[15] = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 2, 4, 6, 0, 4, 0};

  ntt_load_scheduler #(.W(32), .RADIX(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid_i (in_valid_i),
    .in_data_i  (in_data_i),
    .in_ready_o (in_ready_o),
    .tw_reload_i(tw_reload_i),
    .tw_we_o    (tw_we_o),
    .tw_addr_o  (tw_addr_o),
    .tw_data_o  (tw_data_o),
    .ntt_start_o(ntt_start_o),
    .ntt_valid_o(ntt_valid_o),
    .ntt_data_o (ntt_data_o),
    .ntt_done_i (ntt_done_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .overflow_o (overflow_o),
    .dbg_state  (dbg_state)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (tw_we_o != '0) tw_we_cnt++;

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Caller sits at a negedge; the word is sampled on the following posedge.
  task automatic send_word(input logic [31:0] d);
    in_valid_i = 1'b1;
    in_data_i  = d;
    @(negedge clk);
    in_valid_i = 1'b0;
  endtask

  task automatic load_tw(input logic [31:0] base, input int gap, input int abort_at);
    exp_q.delete();
    for (int n = 0; n < 15; n++)
      exp_q.push_back(64'({4'(1 << tw_st[n]), 3'(tw_ad[n]), 32'(base + 32'(tw_off[n]))}));
    for (int i = 0; i < 8; i++) begin
      if (i == 7) check("tw_idle_before_last", 64'({tw_we_o, in_ready_o, busy_o}), 64'({4'b0, 1'b1, 1'b0}));
      send_word(base + 32'(i));
      if (i < 7) repeat (gap) @(negedge clk);
    end
    for (int n = 0; n < 15; n++) begin
      if (n > 0) @(negedge clk);
      check("tw_wr", 64'({tw_we_o, tw_addr_o, tw_data_o}), exp_q.pop_front());
      if (n == abort_at) begin
        #2 rst = 1'b1;
        #1 check("abort_we", 64'({tw_we_o, busy_o, in_ready_o, overflow_o}), 64'(0));
        return;
      end
    end
    @(negedge clk);
    check("tw_end", 64'({tw_we_o, in_ready_o, busy_o, dbg_state}), 64'({4'b0, 1'b1, 1'b0, 3'd2}));
  endtask

  task automatic run_coef(input logic [31:0] base, input int inject_at, input int reload_at);
    int early;
    for (int i = 0; i < 16; i++) begin
      if (i == reload_at) begin
        tw_reload_i = 1'b1;
        @(negedge clk);
        tw_reload_i = 1'b0;
        check("reload_ignored", 64'({dbg_state, in_ready_o, busy_o}), 64'({3'd2, 1'b1, 1'b0}));
      end
      send_word(base + 32'(i));
    end
    for (int k = 0; k < 16; k++) begin
      if (k > 0) @(negedge clk);
      in_valid_i = 1'b0;
      check("beat", 64'({ntt_start_o, ntt_valid_o, ntt_data_o}), 64'({k == 0, 1'b1, 32'(base + 32'(k))}));
      if (k == 0) check("stream_busy", 64'({busy_o, in_ready_o}), 64'(2'b10));
      if (k == inject_at) begin
        in_valid_i = 1'b1;
        in_data_i  = 32'hdead_beef;
      end
    end
    @(negedge clk);
    in_valid_i = 1'b0;
    check("wait_entry", 64'({ntt_valid_o, busy_o, dbg_state}), 64'({1'b0, 1'b1, 3'd4}));
    early = 0;
    repeat (40) begin
      @(negedge clk);
      if (done_o) early++;
    end
    check("no_early_done", 64'(early), 64'(0));
    ntt_done_i = 1'b1;
    @(negedge clk);
    ntt_done_i = 1'b0;
    check("done_pulse", 64'({done_o, busy_o, in_ready_o}), 64'(3'b101));
    @(negedge clk);
    check("done_clear", 64'({done_o, dbg_state}), 64'({1'b0, 3'd2}));
  endtask

  initial begin
    int snap;
    // Reset state
    #12;
    check("reset_outs", 64'({tw_we_o, in_ready_o, ntt_start_o, ntt_valid_o, busy_o, done_o, overflow_o, dbg_state}), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", 64'({in_ready_o, busy_o}), 64'(2'b10));

    // 1. twiddles 100..107, slow UART pacing
    load_tw(32'd100, 870, -1);
    check("tw_write_count", 64'(tw_we_cnt), 64'(15));

    // 2. first transform
    run_coef(32'd0, -1, -1);

    // 3. second transform reuses twiddles
    snap = tw_we_cnt;
    run_coef(32'd200, -1, -1);
    check("no_tw_rewrite", 64'(tw_we_cnt), 64'(snap));
    check("no_overflow_yet", 64'(overflow_o), 64'(0));

    // 4. word injected mid-stream, then stray done during COEF_RX
    run_coef(32'd400, 5, -1);
    check("overflow_set", 64'(overflow_o), 64'(1));
    ntt_done_i = 1'b1;
    @(negedge clk);
    ntt_done_i = 1'b0;
    check("stray_done_0", 64'({done_o, busy_o, dbg_state}), 64'({1'b0, 1'b0, 3'd2}));
    @(negedge clk);
    check("stray_done_1", 64'({done_o, overflow_o}), 64'(2'b01));

    // 6a. reload with ccnt=0
    tw_reload_i = 1'b1;
    @(negedge clk);
    tw_reload_i = 1'b0;
    check("reload_to_twrx", 64'({dbg_state, in_ready_o, busy_o}), 64'({3'd0, 1'b1, 1'b0}));

    // 5. reset mid TW_WR after 5 writes, then full reload
    load_tw(32'd300, 1, 5);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("after_abort", 64'({in_ready_o, tw_we_o, overflow_o, dbg_state}), 64'({1'b1, 4'b0, 1'b0, 3'd0}));
    load_tw(32'd500, 0, -1);

    // 6b. reload with ccnt=3 ignored
    run_coef(32'd600, -1, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
